serialtopara_rx: RTL and testbench

//  Receive end of the device1 serial link: two independent 1-bit lanes, bit clock domain.

---
 rtl/serialtopara_rx.sv | 177 +++++++++++++++++
 tb/tb_serialtopara_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serialtopara_rx.sv
// Receive end of the two-lane serial link: per-lane comma alignment, idle stripping
// and a small payload FIFO per lane with empty/almost-full flags and a shared overflow flag.

// One lane: word aligner FSM, bit counter, shift register and payload FIFO.
// state  | meaning
// SEARCH | hunting for IDLE_WORD on any bit position
// ALIGN  | phase chosen, counting consecutive IDLE_WORDs on word boundaries
// ACTIVE | locked; non-idle words at boundaries are pushed into the FIFO
module serialtopara_rx_lane #(
  parameter int                   DATA_SIZE  = 8,
  parameter logic [DATA_SIZE-1:0] IDLE_WORD  = 8'hBC,
  parameter int                   SYNC_BC    = 4,
  parameter int                   FIFO_DEPTH = 4,
  parameter int                   AF_THRESH  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_bit,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] out_word,
  output logic                 valid_out,
  output logic                 fifo_empty,
  output logic                 fifo_almostfull,
  output logic                 active,
  output logic                 error
);
  localparam int BIT_W = $clog2(DATA_SIZE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  state_t               state, state_nx;
  logic [DATA_SIZE-1:0] shreg, nxt;
  logic [BIT_W-1:0]     bitcnt, bitcnt_nx;
  logic [3:0]           bc_cnt, bc_cnt_nx;
  logic                 boundary, is_idle, push;

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full, do_pop, do_wr, drop;

  assign nxt      = {shreg[DATA_SIZE-2:0], in_bit};
  assign is_idle  = (nxt == IDLE_WORD);
  assign boundary = (bitcnt == BIT_W'(DATA_SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SEARCH;
      shreg  <= '0;
      bitcnt <= '0;
      bc_cnt <= '0;
    end else begin
      state  <= state_nx;
      shreg  <= nxt;
      bitcnt <= bitcnt_nx;
      bc_cnt <= bc_cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    bc_cnt_nx = bc_cnt;
    bitcnt_nx = boundary ? '0 : bitcnt + BIT_W'(1);
    push      = 1'b0;
    case (state)
      SEARCH: begin
        // Any match fixes the word phase: this edge becomes a boundary.
        bitcnt_nx = '0;
        if (is_idle) begin
          state_nx  = ALIGN;
          bc_cnt_nx = 4'd1;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_idle) begin
            bc_cnt_nx = bc_cnt + 4'd1;
            if (bc_cnt + 4'd1 == 4'(SYNC_BC)) state_nx = ACTIVE;
          end else begin
            state_nx  = SEARCH;
            bc_cnt_nx = '0;
          end
        end
      end
      ACTIVE: push = boundary && !is_idle;
      default: state_nx = SEARCH;
    endcase
  end

  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop = pop && (count != '0);
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign do_wr  = push && (!full || do_pop);
  assign drop   = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_word  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= do_pop;
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) begin
        out_word <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) error <= 1'b1;
    end
  end

  assign fifo_empty      = (count == '0);
  assign fifo_almostfull = (count >= CNT_W'(AF_THRESH));
  assign active          = (state == ACTIVE);
endmodule

module serialtopara_rx #(
  parameter int                   DATA_SIZE  = 8,
  parameter logic [DATA_SIZE-1:0] IDLE_WORD  = 8'hBC,
  parameter int                   SYNC_BC    = 4,
  parameter int                   FIFO_DEPTH = 4,
  parameter int                   AF_THRESH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in0,
  input  logic                 in1,
  input  logic                 pop_0,
  input  logic                 pop_1,
  output logic [DATA_SIZE-1:0] out0,
  output logic [DATA_SIZE-1:0] out1,
  output logic                 valid_out0,
  output logic                 valid_out1,
  output logic                 fifo_empty0,
  output logic                 fifo_empty1,
  output logic                 fifo_almostfull0,
  output logic                 fifo_almostfull1,
  output logic                 active0,
  output logic                 active1,
  output logic                 Error
);
  logic error0, error1;

  serialtopara_rx_lane #(
    .DATA_SIZE(DATA_SIZE), .IDLE_WORD(IDLE_WORD), .SYNC_BC(SYNC_BC),
    .FIFO_DEPTH(FIFO_DEPTH), .AF_THRESH(AF_THRESH)
  ) u_lane0 (
    .clk(clk), .rst_n(reset), .in_bit(in0), .pop(pop_0),
    .out_word(out0), .valid_out(valid_out0), .fifo_empty(fifo_empty0),
    .fifo_almostfull(fifo_almostfull0), .active(active0), .error(error0)
  );

  serialtopara_rx_lane #(
    .DATA_SIZE(DATA_SIZE), .IDLE_WORD(IDLE_WORD), .SYNC_BC(SYNC_BC),
    .FIFO_DEPTH(FIFO_DEPTH), .AF_THRESH(AF_THRESH)
  ) u_lane1 (
    .clk(clk), .rst_n(reset), .in_bit(in1), .pop(pop_1),
    .out_word(out1), .valid_out(valid_out1), .fifo_empty(fifo_empty1),
    .fifo_almostfull(fifo_almostfull1), .active(active1), .error(error1)
  );

  assign Error = error0 | error1;
endmodule

// File: tb/tb_serialtopara_rx.sv
// Bench for serialtopara_rx: bit-level lane transmitters, payload scoreboards per lane,
// a table of payload records for the fill/overflow case and hand-written corner sequences.
module tb_serialtopara_rx;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in0 = 1'b0, in1 = 1'b0, pop_0 = 1'b0, pop_1 = 1'b0;
  logic [7:0] out0, out1;
  logic       valid_out0, valid_out1, fifo_empty0, fifo_empty1;
  logic       fifo_almostfull0, fifo_almostfull1, active0, active1, Error;

  serialtopara_rx dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .pop_0(pop_0), .pop_1(pop_1),
    .out0(out0), .out1(out1), .valid_out0(valid_out0), .valid_out1(valid_out1),
    .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
    .fifo_almostfull0(fifo_almostfull0), .fifo_almostfull1(fifo_almostfull1),
    .active0(active0), .active1(active1), .Error(Error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic       tx0[$], tx1[$];
  logic [7:0] sb0[$], sb1[$];
  bit         fill0 = 0, fill1 = 0;

  typedef struct {
    logic [7:0] data;
    logic       exp_empty;
    logic       exp_af;
    logic       exp_err;
    bit         kept;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic enq(input int lane, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      if (lane == 0) tx0.push_back(w[i]);
      else           tx1.push_back(w[i]);
    end
  endtask

  // One bit edge on both lanes; words leave MSB first, idle fill keeps the word phase.
  task automatic step(input logic p0, input logic p1);
    if (tx0.size() == 0 && fill0) enq(0, 8'hBC);
    if (tx1.size() == 0 && fill1) enq(1, 8'hBC);
    in0   = (tx0.size() != 0) ? tx0.pop_front() : 1'b0;
    in1   = (tx1.size() != 0) ? tx1.pop_front() : 1'b0;
    pop_0 = p0;
    pop_1 = p1;
    @(posedge clk);
    #1;
    if (valid_out0) begin
      if (sb0.size() == 0) check("sb0_extra", valid_out0, 0);
      else                 check("sb0_data", out0, sb0.pop_front());
    end
    if (valid_out1) begin
      if (sb1.size() == 0) check("sb1_extra", valid_out1, 0);
      else                 check("sb1_data", out1, sb1.pop_front());
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tx0.delete(); tx1.delete(); sb0.delete(); sb1.delete();
    fill0 = 0; fill1 = 0;
    for (int i = 0; i < 4; i++) begin
      in0   = 1'($urandom_range(0, 1));
      in1   = 1'($urandom_range(0, 1));
      pop_0 = 1'($urandom_range(0, 1));
      pop_1 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_valid", {valid_out0, valid_out1}, 0);
    check("rst_empty", {fifo_empty0, fifo_empty1}, 2'b11);
    check("rst_af", {fifo_almostfull0, fifo_almostfull1}, 0);
    check("rst_active", {active0, active1}, 0);
    check("rst_error", Error, 0);
    in0 = 0; in1 = 0; pop_0 = 0; pop_1 = 0;
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h04, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h05, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset with random inputs, then basic lock and single payload.
    do_reset();
    for (int k = 0; k < 4; k++) enq(0, 8'hBC);
    enq(0, 8'hA5);
    enq(0, 8'hBC);
    sb0.push_back(8'hA5);
    for (int e = 1; e <= 48; e++) begin
      step(1'b0, 1'b0);
      if (e == 31) check("t2_active_e31", active0, 0);
      if (e == 32) check("t2_active_e32", active0, 1);
      if (e == 39) check("t2_empty_e39", fifo_empty0, 1);
      if (e == 40) check("t2_empty_e40", fifo_empty0, 0);
    end
    fill0 = 1;
    step(1'b1, 1'b0);
    check("t2_valid", valid_out0, 1);
    step(1'b0, 1'b0);
    check("t2_valid_one_cycle", valid_out0, 0);
    check("t2_out_hold", out0, 8'hA5);
    check("t2_empty_after_pop", fifo_empty0, 1);
    check("t2_lane1_idle", {active1, fifo_empty1}, 2'b01);

    // Three commas then data: no lock. Then a one-bit-shifted comma stream locks.
    do_reset();
    for (int k = 0; k < 3; k++) enq(0, 8'hBC);
    enq(0, 8'h12);
    run(48);
    check("t3_no_lock", active0, 0);
    check("t3_empty", fifo_empty0, 1);
    tx0.push_back(1'b0);
    for (int k = 0; k < 4; k++) enq(0, 8'hBC);
    for (int e = 1; e <= 33; e++) begin
      step(1'b0, 1'b0);
      if (e == 32) check("t3_shift_e32", active0, 0);
      if (e == 33) check("t3_shift_e33", active0, 1);
    end
    fill0 = 1;

    // Fill to overflow from the record table, then drain.
    for (int i = 0; i < 5; i++) begin
      enq(0, vecs[i].data);
      if (vecs[i].kept) sb0.push_back(vecs[i].data);
      run(8);
      check($sformatf("t4_empty_%0d", i), fifo_empty0, vecs[i].exp_empty);
      check($sformatf("t4_af_%0d", i), fifo_almostfull0, vecs[i].exp_af);
      check($sformatf("t4_err_%0d", i), Error, vecs[i].exp_err);
    end
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("t4_empty_drained", fifo_empty0, 1);
    check("t4_sb_drained", sb0.size(), 0);
    check("t4_err_sticky", Error, 1);
    step(1'b1, 1'b0);
    check("t4_pop_empty_valid", valid_out0, 0);
    check("t4_pop_empty_hold", out0, 8'h04);

    // Full FIFO with pop and push on the same edge.
    do_reset();
    for (int k = 0; k < 4; k++) enq(0, 8'hBC);
    for (int k = 1; k <= 4; k++) begin
      enq(0, 8'(k));
      sb0.push_back(8'(k));
    end
    run(64);
    fill0 = 1;
    check("t5_full_af", fifo_almostfull0, 1);
    enq(0, 8'h66);
    sb0.push_back(8'h66);
    run(7);
    step(1'b1, 1'b0);
    check("t5_err", Error, 0);
    check("t5_af", fifo_almostfull0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      if (i == 2) check("t5_empty_3pops", fifo_empty0, 0);
      if (i == 3) check("t5_empty_4pops", fifo_empty0, 1);
    end
    check("t5_sb_drained", sb0.size(), 0);

    // Mid-word async reset while active, then relock with both lanes running.
    do_reset();
    fill0 = 1;
    run(32);
    check("t6_locked", active0, 1);
    enq(0, 8'h33);
    run(8);
    check("t6_has_word", fifo_empty0, 0);
    enq(0, 8'h77);
    run(4);
    reset = 1'b0;
    #2;
    check("t6_async_active", active0, 0);
    check("t6_async_empty", fifo_empty0, 1);
    check("t6_async_err", Error, 0);
    tx0.delete(); tx1.delete(); sb0.delete(); sb1.delete();
    fill0 = 0;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) enq(0, 8'hBC);
    enq(0, 8'h99);
    sb0.push_back(8'h99);
    for (int k = 0; k < 3; k++) tx1.push_back(1'b0);
    for (int k = 0; k < 4; k++) enq(1, 8'hBC);
    enq(1, 8'h5A);
    enq(1, 8'hC3);
    sb1.push_back(8'h5A);
    sb1.push_back(8'hC3);
    fill0 = 1;
    fill1 = 1;
    for (int e = 1; e <= 56; e++) begin
      step(1'b0, 1'b0);
      if (e == 31) check("t6_relock_e31", active0, 0);
      if (e == 32) check("t6_relock_e32", active0, 1);
      if (e == 34) check("t6_lane1_e34", active1, 0);
      if (e == 35) check("t6_lane1_e35", active1, 1);
    end
    check("t6_empty_both", {fifo_empty0, fifo_empty1}, 2'b00);
    check("t6_af1", fifo_almostfull1, 0);
    check("t6_err", Error, 0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("t6_sb0_drained", sb0.size(), 0);
    check("t6_sb1_drained", sb1.size(), 0);
    check("t6_empty_after", {fifo_empty0, fifo_empty1}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
